dmem_responder: RTL and testbench

Responder end of the pipeline's data-memory interface. Accepts load/store requests from the memory-access stage over a valid/ready handshake. Services each request from a local word array after a fixed, parameterised number of wait states, then returns a response over a second valid/ready handshake. Replaces the zero-wait ram when the pipeline is run against a multi-cycle data memory.

---
 rtl/dmem_responder.sv | 141 ++++++++++++++
 tb/tb_dmem_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the data-memory interface.
// Takes one load/store over a valid/ready request handshake and waits a fixed
// number of cycles. It then services the request from a local word array and
// returns the result over a valid/ready response handshake.
// Optional build macro: DMEM_BYTE_EN_EN adds req_be[3:0] per-byte store enables.
module dmem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 4,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
`ifdef DMEM_BYTE_EN_EN
  input  logic [3:0]            req_be,
`endif
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic                   r_write;
  logic [ADDR_BITS-1:0]   r_idx;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic                   r_mis;
  logic                   r_req_ready;
  logic                   r_resp_valid;
  logic [DATA_WIDTH-1:0]  r_resp_rdata;
  logic                   r_resp_err;
  logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]             r_be;
`endif

  logic [DATA_WIDTH-1:0]  w_cur_word;
  logic [DATA_WIDTH-1:0]  w_store_word;
  logic                   w_unused_addr;

  // Upper address bits take no part in decoding; addresses wrap over the array.
  assign w_unused_addr = ^req_addr[31:ADDR_BITS+2];

  assign w_cur_word = r_mem[r_idx];

`ifdef DMEM_BYTE_EN_EN
  // Merge enabled store lanes into the current word; disabled lanes keep old bytes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_store_word[8*gi +: 8] = r_be[gi] ? r_wdata[8*gi +: 8] : w_cur_word[8*gi +: 8];
  end
`else
  assign w_store_word = r_wdata;
`endif

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  // Request/wait/response FSM plus the word array, with all outputs registered.
  // The counter holds the number of wait cycles still to run. The memory action
  // happens on the edge where it is already 0, so resp_valid rises LATENCY+1
  // edges after the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_mis        <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
`ifdef DMEM_BYTE_EN_EN
      r_be         <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_idx       <= req_addr[ADDR_BITS+1:2];
            r_wdata     <= req_wdata;
            r_mis       <= (req_addr[1:0] != 2'b00);
`ifdef DMEM_BYTE_EN_EN
            r_be        <= req_be;
`endif
            r_cnt       <= 4'(LATENCY);
            r_req_ready <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            if (r_mis) begin
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else if (r_write) begin
              r_mem[r_idx] <= w_store_word;
              r_resp_rdata <= '0;
            end else begin
              r_resp_rdata <= w_cur_word;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised self-checking bench for dmem_responder against an array model.
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int ABITS = 4;
  localparam int DEPTH = 2 ** ABITS;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = 4'hF;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DATA_WIDTH(32), .ADDR_BITS(ABITS), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef DMEM_BYTE_EN_EN
    .req_be     (req_be),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  task automatic do_reset();
    req_valid = 1'b0; resp_ready = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_model();
  endtask

  // One full transaction: expected result comes from the model, then timing,
  // hold stability and retirement are checked.
  task automatic do_txn(input string name, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int hold);
    int          idx;
    int          lat;
    bit          mis;
    logic [31:0] mask;
    logic [31:0] exp_rd;
    logic        exp_err;
    idx  = int'((addr / 4) % DEPTH);
    mis  = (addr % 4) != 0;
`ifdef DMEM_BYTE_EN_EN
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
`else
    mask = 32'hFFFF_FFFF;
`endif
    exp_err = mis;
    exp_rd  = 32'h0;
    if (!mis) begin
      if (wr) model[idx] = (model[idx] & ~mask) | (wdata & mask);
      else    exp_rd = model[idx];
    end
    $display("txn %s wr=%0b addr=%h wdata=%h be=%h hold=%0d exp_rd=%h exp_err=%0b",
             name, wr, addr, wdata, be, hold, exp_rd, exp_err);

    check({name, "/ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    // Junk request held valid while busy; it must be ignored.
    req_valid = 1'b1; req_write = 1'b1; req_addr = $urandom; req_wdata = $urandom; req_be = 4'hF;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      check({name, "/ready_busy"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check({name, "/latency"}, 32'(lat), 32'(LAT + 1));
    for (int h = 0; h < hold; h++) begin
      check({name, "/hold_valid"}, 32'(resp_valid), 32'd1);
      check({name, "/hold_rdata"}, resp_rdata, exp_rd);
      check({name, "/hold_err"}, 32'(resp_err), 32'(exp_err));
      check({name, "/hold_ready"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    check({name, "/valid"}, 32'(resp_valid), 32'd1);
    check({name, "/rdata"}, resp_rdata, exp_rd);
    check({name, "/err"}, 32'(resp_err), 32'(exp_err));
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({name, "/retired"}, 32'(resp_valid), 32'd0);
    check({name, "/err_clr"}, 32'(resp_err), 32'd0);
    check({name, "/ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset/req_ready", 32'(req_ready), 32'd1);
    check("reset/resp_valid", 32'(resp_valid), 32'd0);
    check("reset/resp_rdata", resp_rdata, 32'h0);
    check("reset/resp_err", 32'(resp_err), 32'd0);

    do_txn("load_0c", 1'b0, 32'h0C, 32'h0, 4'hF, 0);
    do_txn("store_08", 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 0);
    do_txn("load_08", 1'b0, 32'h08, 32'h0, 4'hF, 0);
    check("model_08", model[2], 32'hDEADBEEF);
    do_txn("load_48_wrap", 1'b0, 32'h48, 32'h0, 4'hF, 0);
    do_txn("store_04", 1'b1, 32'h04, 32'h12345678, 4'hF, 0);
    do_txn("store_06_mis", 1'b1, 32'h06, 32'hFFFFFFFF, 4'hF, 0);
    do_txn("load_04", 1'b0, 32'h04, 32'h0, 4'hF, 0);
    do_txn("load_08_hold5", 1'b0, 32'h08, 32'h0, 4'hF, 5);

    // Reset while a store to 0x10 is waiting: no response, no write.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    $display("txn reset_mid_wait addr=00000010");
    do_reset();
    for (int c = 0; c < LAT + 3; c++) begin
      check("rst_wait/resp_valid", 32'(resp_valid), 32'd0);
      check("rst_wait/req_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
    end
    do_txn("load_10_after_rst", 1'b0, 32'h10, 32'h0, 4'hF, 0);
    do_txn("load_08_after_rst", 1'b0, 32'h08, 32'h0, 4'hF, 0);

`ifdef DMEM_BYTE_EN_EN
    do_txn("be_full", 1'b1, 32'h20, 32'hAABBCCDD, 4'b1111, 0);
    do_txn("be_0101", 1'b1, 32'h20, 32'h11223344, 4'b0101, 0);
    do_txn("be_load", 1'b0, 32'h20, 32'h0, 4'b0000, 0);
    check("be_model", model[8], 32'hAA22CC44);
    do_txn("be_none", 1'b1, 32'h20, 32'h55555555, 4'b0000, 0);
    do_txn("be_load2", 1'b0, 32'h20, 32'h0, 4'b1010, 0);
`endif

    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 255), 2'b00} + 32'($urandom_range(0, 3) << 30);
      a[ABITS+1:2] = 4'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      do_txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), a, $urandom,
             4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
